// File: rtl/alu_issue_ctrl.sv
// ALU issue control: decodes ALUOp/funct, registers operands and control, and holds them for multi-cycle MUL.
// Multiply support (MUL_WAIT state and hold counter) is built only when ALU_ISSUE_MUL_EN is defined.
module alu_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       ALUOp_i,
    input  logic [9:0]       funct_i,
    input  logic             ALUSrc_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic             flush_i,
    output logic [2:0]       ALUCtrl_o,
    output logic [WIDTH-1:0] data1_o,
    output logic [WIDTH-1:0] data2_o,
    output logic             valid_o,
    output logic             illegal_o
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_MUL = 3'b011;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_BAD = 3'b111;

    generate
        if (MUL_LAT < 1) begin : g_mul_lat_check
            $error("MUL_LAT must be at least 1");
        end
    endgenerate

`ifdef ALU_ISSUE_MUL_EN
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, MUL_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE} state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_mul;
    logic       illegal_q;
    logic       accept;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_ctrl = CTRL_BAD;
        dec_mul  = 1'b0;
        case (ALUOp_i)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (funct_i)
                    10'b0000000_111: dec_ctrl = CTRL_AND;
                    10'b0000000_110: dec_ctrl = CTRL_OR;
                    10'b0000000_000: dec_ctrl = CTRL_ADD;
                    10'b0100000_000: dec_ctrl = CTRL_SUB;
`ifdef ALU_ISSUE_MUL_EN
                    10'b0000001_000: begin
                        dec_ctrl = CTRL_MUL;
                        dec_mul  = 1'b1;
                    end
`endif
                    default:         dec_ctrl = CTRL_BAD;
                endcase
            end
            default: begin
                // I-type ignores funct7 entirely
                case (funct_i[2:0])
                    3'b000:  dec_ctrl = CTRL_ADD;
                    3'b111:  dec_ctrl = CTRL_AND;
                    3'b110:  dec_ctrl = CTRL_OR;
                    default: dec_ctrl = CTRL_BAD;
                endcase
            end
        endcase
    end

    assign dec_illegal = (dec_ctrl == CTRL_BAD);
    assign accept      = valid_i & ready_o & ~flush_i;

`ifdef ALU_ISSUE_MUL_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign ready_o = (state_q != MUL_WAIT) || (cnt_q == '0);
    assign valid_o = (state_q == ISSUE) || ((state_q == MUL_WAIT) && (cnt_q == '0));

    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        if ((state_q == MUL_WAIT) && (cnt_q != '0)) begin
            state_d = MUL_WAIT;
            cnt_d   = cnt_q - 1'b1;
        end
        if (accept) begin
            if (dec_mul && (MUL_LAT > 1)) begin
                state_d = MUL_WAIT;
                cnt_d   = CNT_W'(MUL_LAT - 1);
            end else begin
                state_d = ISSUE;
            end
        end
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign ready_o = 1'b1;
    assign valid_o = (state_q == ISSUE);

    always_comb begin
        state_d = IDLE;
        if (accept) begin
            state_d = ISSUE;
        end
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic unused_mul;
    assign unused_mul = dec_mul;
`endif

    // Operand/control registers only move on accept, so they stay frozen through MUL_WAIT and IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ALUCtrl_o <= CTRL_AND;
            data1_o   <= '0;
            data2_o   <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            ALUCtrl_o <= dec_ctrl;
            data1_o   <= rs1_data_i;
            data2_o   <= ALUSrc_i ? imm_i : rs2_data_i;
            illegal_q <= dec_illegal;
        end
    end

    assign illegal_o = valid_o & illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: decode table, multi-cycle corner sequences and a randomized run
// against a transaction-level reference model. Follows ALU_ISSUE_MUL_EN the same way the design does.
module tb_alu_issue_ctrl;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 4;
`ifdef ALU_ISSUE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       ALUOp_i;
    logic [9:0]       funct_i;
    logic             ALUSrc_i;
    logic [WIDTH-1:0] rs1_data_i;
    logic [WIDTH-1:0] rs2_data_i;
    logic [WIDTH-1:0] imm_i;
    logic             flush_i;
    logic [2:0]       ALUCtrl_o;
    logic [WIDTH-1:0] data1_o;
    logic [WIDTH-1:0] data2_o;
    logic             valid_o;
    logic             illegal_o;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .ALUOp_i    (ALUOp_i),
        .funct_i    (funct_i),
        .ALUSrc_i   (ALUSrc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .imm_i      (imm_i),
        .flush_i    (flush_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .data1_o    (data1_o),
        .data2_o    (data2_o),
        .valid_o    (valid_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the last accepted transaction and how many cycles remain until its result
    // is valid (-1 = nothing pending).
    int         m_wait;
    logic [2:0] m_ctrl;
    logic [31:0] m_d1, m_d2;
    bit         m_ill;

    function automatic void ref_decode(input logic [1:0] op, input logic [9:0] f,
                                       output logic [2:0] ctrl, output bit is_mul);
        int    f7, f3;
        string kind;
        f7   = int'(f[9:3]);
        f3   = int'(f[2:0]);
        kind = "BAD";
        if (op == 2'd0) kind = "ADD";
        else if (op == 2'd1) kind = "SUB";
        else if (op == 2'd2) begin
            if (f7 == 0 && f3 == 7) kind = "AND";
            else if (f7 == 0 && f3 == 6) kind = "OR";
            else if (f7 == 0 && f3 == 0) kind = "ADD";
            else if (f7 == 32 && f3 == 0) kind = "SUB";
            else if (f7 == 1 && f3 == 0 && MUL_EN) kind = "MUL";
        end else begin
            if (f3 == 0) kind = "ADD";
            else if (f3 == 7) kind = "AND";
            else if (f3 == 6) kind = "OR";
        end
        is_mul = (kind == "MUL") && (MUL_LAT > 1);
        case (kind)
            "AND":   ctrl = 3'b000;
            "OR":    ctrl = 3'b001;
            "ADD":   ctrl = 3'b010;
            "SUB":   ctrl = 3'b110;
            "MUL":   ctrl = 3'b011;
            default: ctrl = 3'b111;
        endcase
    endfunction

    task automatic model_reset();
        m_wait = -1;
        m_ctrl = 3'b000;
        m_d1   = '0;
        m_d2   = '0;
        m_ill  = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] c;
        bit         mul;
        bit         rdy;
        rdy = (m_wait <= 0);
        if (flush_i) begin
            m_wait = -1;
        end else if (valid_i && rdy) begin
            ref_decode(ALUOp_i, funct_i, c, mul);
            m_ctrl = c;
            m_ill  = (c == 3'b111);
            m_d1   = rs1_data_i;
            m_d2   = ALUSrc_i ? imm_i : rs2_data_i;
            m_wait = mul ? MUL_LAT - 1 : 0;
        end else if (m_wait >= 0) begin
            m_wait--;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},   valid_o,   m_wait == 0);
        check({tag, ".illegal"}, illegal_o, (m_wait == 0) && m_ill);
        check({tag, ".ready"},   ready_o,   m_wait <= 0);
        check({tag, ".ctrl"},    ALUCtrl_o, m_ctrl);
        check({tag, ".data1"},   data1_o,   m_d1);
        check({tag, ".data2"},   data2_o,   m_d2);
    endtask

    // Called at a falling edge; returns at the next falling edge with model and DUT compared.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [9:0] f, input bit src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input bit fl);
        valid_i    = v;
        ALUOp_i    = op;
        funct_i    = f;
        ALUSrc_i   = src;
        rs1_data_i = a;
        rs2_data_i = b;
        imm_i      = im;
        flush_i    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 10'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic apply_reset(input string tag);
        rst_i = 1'b1;
        #1;
        check({tag, ".ready"},   ready_o,   1'b1);
        check({tag, ".valid"},   valid_o,   1'b0);
        check({tag, ".illegal"}, illegal_o, 1'b0);
        check({tag, ".ctrl"},    ALUCtrl_o, 3'b000);
        check({tag, ".data1"},   data1_o,   32'd0);
        check({tag, ".data2"},   data2_o,   32'd0);
        model_reset();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  funct;
        bit          src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [2:0]  exp_ctrl;
        bit          exp_ill;
        logic [31:0] exp_d2;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        logic [9:0] rf;

        // The first four rows form the back-to-back R-type stream.
        vecs[0]  = '{2'b10, 10'b0000000_111, 1'b0, 32'hC, 32'hA, 32'h0, 3'b000, 1'b0, 32'hA};
        vecs[1]  = '{2'b10, 10'b0000000_110, 1'b0, 32'hC, 32'hA, 32'h0, 3'b001, 1'b0, 32'hA};
        vecs[2]  = '{2'b10, 10'b0000000_000, 1'b0, 32'hC, 32'hA, 32'h0, 3'b010, 1'b0, 32'hA};
        vecs[3]  = '{2'b10, 10'b0100000_000, 1'b0, 32'hC, 32'hA, 32'h0, 3'b110, 1'b0, 32'hA};
        vecs[4]  = '{2'b00, 10'b1111111_111, 1'b1, 32'h100, 32'h9, 32'h10, 3'b010, 1'b0, 32'h10};
        vecs[5]  = '{2'b01, 10'b0000001_000, 1'b0, 32'h7, 32'h8, 32'h55, 3'b110, 1'b0, 32'h8};
        vecs[6]  = '{2'b11, 10'b1111111_000, 1'b1, 32'h5, 32'h3, 32'hFFFFFFFF, 3'b010, 1'b0, 32'hFFFFFFFF};
        vecs[7]  = '{2'b11, 10'b0100000_111, 1'b1, 32'hF0, 32'h3, 32'h3C, 3'b000, 1'b0, 32'h3C};
        vecs[8]  = '{2'b11, 10'b0000000_110, 1'b1, 32'hF0, 32'h3, 32'h0F, 3'b001, 1'b0, 32'h0F};
        vecs[9]  = '{2'b10, 10'b0000000_001, 1'b0, 32'h1, 32'h2, 32'h0, 3'b111, 1'b1, 32'h2};
        vecs[10] = '{2'b11, 10'b0000000_001, 1'b1, 32'h1, 32'h2, 32'h44, 3'b111, 1'b1, 32'h44};
        vecs[11] = '{2'b10, 10'b0100000_111, 1'b0, 32'h6, 32'h2, 32'h0, 3'b111, 1'b1, 32'h2};
        vecs[12] = '{2'b10, 10'b0000001_000, 1'b0, 32'h3, 32'h7, 32'h0,
                     MUL_EN ? 3'b011 : 3'b111, !MUL_EN, 32'h7};

        rst_i = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        apply_reset("reset");
        check_model("post_reset");

        // Decode table, applied back-to-back; each row is checked on its valid_o cycle.
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].funct, vecs[i].src,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0);
            tick($sformatf("tbl%0d", i));
            idle();
            for (int w = 0; w < MUL_LAT + 2 && valid_o !== 1'b1; w++) tick($sformatf("tbl%0d_wait", i));
            check($sformatf("tbl%0d.valid", i),   valid_o,   1'b1);
            check($sformatf("tbl%0d.ctrl", i),    ALUCtrl_o, vecs[i].exp_ctrl);
            check($sformatf("tbl%0d.illegal", i), illegal_o, vecs[i].exp_ill);
            check($sformatf("tbl%0d.data1", i),   data1_o,   vecs[i].rs1);
            check($sformatf("tbl%0d.data2", i),   data2_o,   vecs[i].exp_d2);
        end
        tick("tbl_drain");
        check("idle_hold.valid", valid_o, 1'b0);
        check("idle_hold.data1", data1_o, 32'h3);

`ifdef ALU_ISSUE_MUL_EN
        // MUL: three stall cycles, valid on the fourth, next op accepted in the valid cycle.
        drive(1'b1, 2'b10, 10'b0000001_000, 1'b0, 32'd3, 32'd7, 32'd0, 1'b0);
        tick("mul_acc");
        idle();
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            check($sformatf("mul_stall%0d.ready", k), ready_o, 1'b0);
            check($sformatf("mul_stall%0d.valid", k), valid_o, 1'b0);
            check($sformatf("mul_stall%0d.data1", k), data1_o, 32'd3);
            check($sformatf("mul_stall%0d.data2", k), data2_o, 32'd7);
            tick($sformatf("mul_stall%0d", k));
        end
        check("mul_done.valid", valid_o,   1'b1);
        check("mul_done.ready", ready_o,   1'b1);
        check("mul_done.ctrl",  ALUCtrl_o, 3'b011);
        drive(1'b1, 2'b10, 10'b0000000_000, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0);
        tick("mul_next");
        idle();
        check("mul_next.ctrl",  ALUCtrl_o, 3'b010);
        check("mul_next.valid", valid_o,   1'b1);

        // Flush in MUL_WAIT with cnt==2: multiply aborted, competing op not accepted.
        drive(1'b1, 2'b10, 10'b0000001_000, 1'b0, 32'd9, 32'd4, 32'd0, 1'b0);
        tick("fl_acc");
        idle();
        tick("fl_wait");
        drive(1'b1, 2'b00, 10'd0, 1'b0, 32'hAA, 32'hBB, 32'd0, 1'b1);
        tick("fl_hit");
        idle();
        check("fl_hit.valid", valid_o,   1'b0);
        check("fl_hit.ready", ready_o,   1'b1);
        check("fl_hit.ctrl",  ALUCtrl_o, 3'b011);
        check("fl_hit.data1", data1_o,   32'd9);
        for (int k = 0; k < MUL_LAT + 1; k++) tick($sformatf("fl_after%0d", k));
`else
        // Without multiply support the MUL encoding is a plain single-cycle illegal op.
        drive(1'b1, 2'b10, 10'b0000001_000, 1'b0, 32'd3, 32'd7, 32'd0, 1'b0);
        check("nomul.ready_before", ready_o, 1'b1);
        tick("nomul");
        idle();
        check("nomul.illegal", illegal_o, 1'b1);
        check("nomul.ctrl",    ALUCtrl_o, 3'b111);
        check("nomul.ready",   ready_o,   1'b1);

        // Flush competing with a new op right after an accept.
        drive(1'b1, 2'b10, 10'b0000000_111, 1'b0, 32'h11, 32'h22, 32'd0, 1'b0);
        tick("fl_acc");
        drive(1'b1, 2'b10, 10'b0000000_110, 1'b0, 32'h33, 32'h44, 32'd0, 1'b1);
        tick("fl_hit");
        idle();
        check("fl_hit.valid", valid_o,   1'b0);
        check("fl_hit.ctrl",  ALUCtrl_o, 3'b000);
        check("fl_hit.data1", data1_o,   32'h11);
`endif

        // Illegal op followed by a flush in its valid cycle: illegal_o must drop with valid_o.
        drive(1'b1, 2'b10, 10'b0000000_001, 1'b0, 32'h5, 32'h6, 32'd0, 1'b0);
        tick("ill_acc");
        check("ill_acc.illegal", illegal_o, 1'b1);
        drive(1'b0, 2'b00, 10'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick("ill_flush");
        idle();
        check("ill_flush.illegal", illegal_o, 1'b0);

        // Reset while an op (a multiply when enabled) is in flight.
        drive(1'b1, 2'b10, 10'b0000001_000, 1'b0, 32'h123, 32'h456, 32'd0, 1'b0);
        tick("rst_mid_acc");
        idle();
        tick("rst_mid_run");
        apply_reset("rst_mid");
        check_model("rst_mid_after");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0:       rf = 10'b0000000_111;
                1:       rf = 10'b0000000_110;
                2:       rf = 10'b0000000_000;
                3:       rf = 10'b0100000_000;
                4:       rf = 10'b0000001_000;
                5:       rf = 10'b0000000_001;
                default: rf = 10'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rf, 1'($urandom),
                  $urandom, $urandom, $urandom, $urandom_range(0, 9) == 0);
            tick("rnd");
        end
        idle();
        tick("rnd_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
